mac_accumulator: RTL and testbench



---
 rtl/mac_pkg.sv | 18 +
 rtl/acc_add_sat.sv | 31 +++
 rtl/mac_accumulator.sv | 97 +++++++++
 tb/tb_mac_accumulator.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and default constants for the MAC accumulator slice.
package mac_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    localparam int DEF_N     = 4;
    localparam int DEF_ACC_W = 10;
    localparam int DEF_CNT_W = 4;

    localparam logic [DEF_ACC_W-1:0] SAT_VAL = {DEF_ACC_W{1'b1}};

endpackage

// File: rtl/acc_add_sat.sv
// Widening accumulator adder with carry-out; clamps to all-ones on carry when
// SATURATE_EN is defined, otherwise wraps.
module acc_add_sat
    import mac_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W-1:0] i_acc,
    input  logic [7:0]       i_p,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_carry
);

    logic [ACC_W:0] w_sum;

    // Add in ACC_W+1 bits so the top bit is the carry-out.
    always_comb begin
        w_sum   = {1'b0, i_acc} + {{(ACC_W-7){1'b0}}, i_p};
        o_carry = w_sum[ACC_W];
`ifdef SATURATE_EN
        if (w_sum[ACC_W]) begin
            o_sum = {ACC_W{1'b1}};
        end else begin
            o_sum = w_sum[ACC_W-1:0];
        end
`else
        o_sum = w_sum[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/mac_accumulator.sv
// Frame accumulator: sums N accepted products, presents the sum on a
// valid/ready handshake with a sticky overflow flag. Optional macro: SATURATE_EN.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int ACC_W = DEF_ACC_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       i_p_in,
    input  logic             i_p_valid,
    output logic             o_in_ready,
    input  logic             i_clear,
    output logic [ACC_W-1:0] o_acc_out,
    output logic             o_acc_valid,
    input  logic             i_acc_ready,
    output logic             o_ovf
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;

    logic [ACC_W-1:0] w_sum;
    logic             w_carry;
    logic             w_accept;

    acc_add_sat #(
        .ACC_W (ACC_W)
    ) u_add (
        .i_acc   (r_acc),
        .i_p     (i_p_in),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // in_ready depends only on state and clear, never on p_valid.
    assign o_in_ready  = (r_state == ST_ACCUM) && !i_clear;
    assign w_accept    = o_in_ready && i_p_valid;
    assign o_acc_valid = (r_state == ST_HOLD);
    assign o_acc_out   = r_acc;
    assign o_ovf       = r_ovf;

    // Frame state, counter, accumulator and sticky overflow; clear wins over everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
            r_cnt   <= {CNT_W{1'b0}};
            r_acc   <= {ACC_W{1'b0}};
            r_ovf   <= 1'b0;
        end else if (i_clear) begin
            r_state <= ST_ACCUM;
            r_cnt   <= {CNT_W{1'b0}};
            r_acc   <= {ACC_W{1'b0}};
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_sum;
                        r_ovf <= r_ovf | w_carry;
                        if (r_cnt == CNT_LAST) begin
                            r_state <= ST_HOLD;
                            r_cnt   <= {CNT_W{1'b0}};
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_acc <= r_acc;
                    end
                end
                ST_HOLD: begin
                    if (i_acc_ready) begin
                        r_state <= ST_ACCUM;
                        r_cnt   <= {CNT_W{1'b0}};
                        r_acc   <= {ACC_W{1'b0}};
                        r_ovf   <= 1'b0;
                    end else begin
                        r_state <= ST_HOLD;
                    end
                end
                default: begin
                    r_state <= ST_ACCUM;
                    r_cnt   <= {CNT_W{1'b0}};
                    r_acc   <= {ACC_W{1'b0}};
                    r_ovf   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: three instances (N=4, N=16, N=1) share stimulus and
// are checked every cycle against a frame-level sum model plus literal expectations.
module tb_mac_accumulator;

    logic       clk;
    logic       rst_n;
    logic [7:0] p_in;
    logic       p_valid;
    logic       clear;
    logic       acc_ready;

    logic       in_ready  [3];
    logic [9:0] acc_out   [3];
    logic       acc_valid [3];
    logic       ovf       [3];

    int checks;
    int failures;

    int m_sum  [3];
    int m_cnt  [3];
    bit m_hold [3];

    mac_accumulator #(.N(4), .ACC_W(10), .CNT_W(4)) u_n4 (
        .clk(clk), .rst_n(rst_n), .i_p_in(p_in), .i_p_valid(p_valid),
        .o_in_ready(in_ready[0]), .i_clear(clear), .o_acc_out(acc_out[0]),
        .o_acc_valid(acc_valid[0]), .i_acc_ready(acc_ready), .o_ovf(ovf[0]));

    mac_accumulator #(.N(16), .ACC_W(10), .CNT_W(4)) u_n16 (
        .clk(clk), .rst_n(rst_n), .i_p_in(p_in), .i_p_valid(p_valid),
        .o_in_ready(in_ready[1]), .i_clear(clear), .o_acc_out(acc_out[1]),
        .o_acc_valid(acc_valid[1]), .i_acc_ready(acc_ready), .o_ovf(ovf[1]));

    mac_accumulator #(.N(1), .ACC_W(10), .CNT_W(4)) u_n1 (
        .clk(clk), .rst_n(rst_n), .i_p_in(p_in), .i_p_valid(p_valid),
        .o_in_ready(in_ready[2]), .i_clear(clear), .o_acc_out(acc_out[2]),
        .o_acc_valid(acc_valid[2]), .i_acc_ready(acc_ready), .o_ovf(ovf[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int n_of(input int i);
        case (i)
            0:       return 4;
            1:       return 16;
            default: return 1;
        endcase
    endfunction

    // Expected output from the true (unbounded) frame sum.
    function automatic int exp_acc(input int s);
`ifdef SATURATE_EN
        return (s > 1023) ? 1023 : s;
`else
        return s % 1024;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: running sum, products taken, and whether a result is held.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_sum[i]  <= 0;
                m_cnt[i]  <= 0;
                m_hold[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (clear) begin
                    m_sum[i]  <= 0;
                    m_cnt[i]  <= 0;
                    m_hold[i] <= 1'b0;
                end else if (m_hold[i]) begin
                    if (acc_ready) begin
                        m_sum[i]  <= 0;
                        m_cnt[i]  <= 0;
                        m_hold[i] <= 1'b0;
                    end
                end else if (p_valid) begin
                    m_sum[i] <= m_sum[i] + int'(p_in);
                    if (m_cnt[i] + 1 == n_of(i)) begin
                        m_hold[i] <= 1'b1;
                        m_cnt[i]  <= 0;
                    end else begin
                        m_cnt[i] <= m_cnt[i] + 1;
                    end
                end
            end
        end
    end

    // Every-cycle compare on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("inst%0d acc_out", i), int'(acc_out[i]), exp_acc(m_sum[i]));
                chk($sformatf("inst%0d acc_valid", i), int'(acc_valid[i]), int'(m_hold[i]));
                chk($sformatf("inst%0d ovf", i), int'(ovf[i]), (m_sum[i] > 1023) ? 1 : 0);
                chk($sformatf("inst%0d in_ready", i), int'(in_ready[i]),
                    (!m_hold[i] && !clear) ? 1 : 0);
            end
        end
    end

    task automatic cyc(input bit pv, input int p, input bit clr, input bit rdy);
        p_valid   = pv;
        p_in      = 8'(p);
        clear     = clr;
        acc_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        p_in      = 8'd0;
        p_valid   = 1'b0;
        clear     = 1'b0;
        acc_ready = 1'b0;
        #12;
        chk("reset acc_out", int'(acc_out[0]), 0);
        chk("reset acc_valid", int'(acc_valid[0]), 0);
        chk("reset ovf", int'(ovf[0]), 0);
        chk("reset in_ready", int'(in_ready[0]), 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 225 x4 back-to-back on N=4
        cyc(1'b0, 0, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) cyc(1'b1, 225, 1'b0, 1'b1);
        chk("n4 sum900", int'(acc_out[0]), 900);
        chk("n4 ovf0", int'(ovf[0]), 0);
        chk("n4 valid hi", int'(acc_valid[0]), 1);
        chk("n4 in_ready lo", int'(in_ready[0]), 0);
        cyc(1'b0, 0, 1'b0, 1'b1);
        chk("n4 valid one cycle", int'(acc_valid[0]), 0);
        chk("n4 in_ready back", int'(in_ready[0]), 1);

        // 225 x16 on N=16 overflows
        cyc(1'b0, 0, 1'b1, 1'b1);
        for (int k = 0; k < 16; k++) cyc(1'b1, 225, 1'b0, 1'b1);
`ifdef SATURATE_EN
        chk("n16 sat", int'(acc_out[1]), 1023);
`else
        chk("n16 wrap", int'(acc_out[1]), 528);
`endif
        chk("n16 ovf", int'(ovf[1]), 1);
        chk("n16 valid", int'(acc_valid[1]), 1);

        // Backpressure: held result stays put while producer keeps pushing
        cyc(1'b0, 0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) cyc(1'b1, 3, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 50, 1'b0, 1'b0);
            chk("hold acc", int'(acc_out[0]), 12);
            chk("hold valid", int'(acc_valid[0]), 1);
            chk("hold in_ready", int'(in_ready[0]), 0);
        end
        cyc(1'b0, 0, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) cyc(1'b1, 1, 1'b0, 1'b1);
        chk("after hold restart", int'(acc_out[0]), 4);

        // Clear mid-frame
        cyc(1'b0, 0, 1'b0, 1'b1);
        cyc(1'b0, 0, 1'b1, 1'b1);
        cyc(1'b1, 10, 1'b0, 1'b1);
        cyc(1'b1, 20, 1'b0, 1'b1);
        cyc(1'b1, 99, 1'b1, 1'b1);
        for (int k = 1; k <= 4; k++) cyc(1'b1, k, 1'b0, 1'b1);
        chk("clear sum10", int'(acc_out[0]), 10);
        chk("clear valid", int'(acc_valid[0]), 1);

        // Asynchronous reset between edges
        cyc(1'b0, 0, 1'b0, 1'b1);
        cyc(1'b1, 5, 1'b0, 1'b1);
        cyc(1'b1, 5, 1'b0, 1'b1);
        p_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async acc_out", int'(acc_out[0]), 0);
        chk("async ovf", int'(ovf[0]), 0);
        chk("async in_ready", int'(in_ready[0]), 1);
        chk("async n1 valid", int'(acc_valid[2]), 0);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) cyc(1'b1, 5, 1'b0, 1'b1);
        chk("post reset sum20", int'(acc_out[0]), 20);

        // N=1 frames
        cyc(1'b0, 0, 1'b1, 1'b1);
        cyc(1'b1, 7, 1'b0, 1'b1);
        chk("n1 first", int'(acc_out[2]), 7);
        chk("n1 first valid", int'(acc_valid[2]), 1);
        chk("n1 first ovf", int'(ovf[2]), 0);
        cyc(1'b0, 0, 1'b0, 1'b1);
        cyc(1'b1, 9, 1'b0, 1'b1);
        chk("n1 second", int'(acc_out[2]), 9);
        chk("n1 second ovf", int'(ovf[2]), 0);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            cyc(($urandom_range(9) < 7), int'($urandom_range(255)),
                ($urandom_range(39) == 0), ($urandom_range(1) == 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
